drum_timing_gen: RTL and testbench

// - Bit/word timing generator for the G-15 drum. Upstream of memory lines 0-6,

---
 rtl/drum_timing_gen_if.sv | 31 +++
 rtl/drum_timing_gen.sv | 87 ++++++++
 tb/tb_drum_timing_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/drum_timing_gen_if.sv
// Timing bundle between the G-15 drum timing generator (master) and its consumers (slave).
// No handshake: HOLD/ORIGIN are sampled on every CLOCK edge; all outputs are valid every cycle.
interface drum_timing_gen_if;
    logic       HOLD;
    logic       ORIGIN;
    logic [4:0] BIT_TIME;
    logic [6:0] WORD_TIME;
    logic       T1;
    logic       T2;
    logic       T13;
    logic       T21;
    logic       T28;
    logic       T29;
    logic       ODD_WORD;
    logic       WORD_END;
    logic       REV_END;
    logic       QUAD_END;
    logic       SYNC_ERR;

    modport master (
        input  HOLD, ORIGIN,
        output BIT_TIME, WORD_TIME, T1, T2, T13, T21, T28, T29,
               ODD_WORD, WORD_END, REV_END, QUAD_END, SYNC_ERR
    );

    modport slave (
        output HOLD, ORIGIN,
        input  BIT_TIME, WORD_TIME, T1, T2, T13, T21, T28, T29,
               ODD_WORD, WORD_END, REV_END, QUAD_END, SYNC_ERR
    );
endinterface

// File: rtl/drum_timing_gen.sv
// G-15 drum bit/word timing generator: bit-in-word and word-on-drum counters plus strobe decodes.
// Optional macro G15_TIMING_ORIGIN_EN enables origin-track resync and the sticky SYNC_ERR flag.
module drum_timing_gen #(
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108
) (
    input  logic               CLOCK,
    input  logic               rst,
    drum_timing_gen_if.master  tif
);
    localparam logic [4:0] LAST_BIT  = 5'(BITS_PER_WORD);
    localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_REV - 1);

    logic [4:0] bit_time_q,  bit_time_d;
    logic [6:0] word_time_q, word_time_d;
    logic       sync_err_q,  sync_err_d;
    logic       last_bit;
    logic       rev_end;
    logic       in_range;

    assign last_bit = (bit_time_q == LAST_BIT);
    assign rev_end  = last_bit && (word_time_q == LAST_WORD);
    assign in_range = (bit_time_q != 5'd0) && (bit_time_q <= LAST_BIT) &&
                      (word_time_q <= LAST_WORD);

`ifndef G15_TIMING_ORIGIN_EN
    logic unused_origin;
    assign unused_origin = tif.ORIGIN;
`endif

    always_comb begin
        bit_time_d  = bit_time_q;
        word_time_d = word_time_q;
        sync_err_d  = sync_err_q;
        // A corrupted count recovers on the next edge even while held.
        if (!in_range) begin
            bit_time_d  = 5'd1;
            word_time_d = 7'd0;
        end else if (!tif.HOLD) begin
            if (last_bit) begin
                bit_time_d  = 5'd1;
                word_time_d = (word_time_q == LAST_WORD) ? 7'd0 : word_time_q + 7'd1;
            end else begin
                bit_time_d  = bit_time_q + 5'd1;
            end
`ifdef G15_TIMING_ORIGIN_EN
            // Origin at REV_END matches the natural wrap; anywhere else is a slip.
            if (tif.ORIGIN) begin
                bit_time_d  = 5'd1;
                word_time_d = 7'd0;
                if (!rev_end) begin
                    sync_err_d = 1'b1;
                end
            end
`endif
        end
`ifndef G15_TIMING_ORIGIN_EN
        sync_err_d = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            bit_time_q  <= 5'd1;
            word_time_q <= 7'd0;
            sync_err_q  <= 1'b0;
        end else begin
            bit_time_q  <= bit_time_d;
            word_time_q <= word_time_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign tif.BIT_TIME  = bit_time_q;
    assign tif.WORD_TIME = word_time_q;
    assign tif.T1        = (bit_time_q == 5'd1);
    assign tif.T2        = (bit_time_q == 5'd2);
    assign tif.T13       = (bit_time_q == 5'd13);
    assign tif.T21       = (bit_time_q == 5'd21);
    assign tif.T28       = (bit_time_q == 5'd28);
    assign tif.T29       = last_bit;
    assign tif.ODD_WORD  = word_time_q[0];
    assign tif.WORD_END  = last_bit;
    assign tif.REV_END   = rev_end;
    assign tif.QUAD_END  = last_bit && (word_time_q[1:0] == 2'b11);
    assign tif.SYNC_ERR  = sync_err_q;
endmodule

// File: tb/tb_drum_timing_gen.sv
// Directed bench for drum_timing_gen: a step table walked from reset plus hand-written
// sequences for the full revolution, async reset, and (when enabled) origin resync.
module tb_drum_timing_gen;
    logic CLOCK;
    logic rst;
    int   n_tests;
    int   n_fail;

    drum_timing_gen_if tif ();

    drum_timing_gen dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .tif   (tif)
    );

    // clock / reset
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // {T1,T2,T13,T21,T28,T29,ODD_WORD,WORD_END,REV_END,QUAD_END}
    function automatic logic [9:0] strobes();
        return {tif.T1, tif.T2, tif.T13, tif.T21, tif.T28, tif.T29,
                tif.ODD_WORD, tif.WORD_END, tif.REV_END, tif.QUAD_END};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tif.HOLD = 1'b0;
        tif.ORIGIN = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       hold;
        int         n_clk;
        logic [4:0] exp_bit;
        logic [6:0] exp_word;
        logic [9:0] exp_strb;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int t1_count;
        int rev_cycle;
        int rev_count;
        int track_err;
        logic [11:0] exp_q[$];
        logic [11:0] exp_pos;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        tif.HOLD = 1'b0;
        tif.ORIGIN = 1'b0;

        vecs[0]  = '{1'b0, 0,  5'd1,  7'd0, 10'b1000000000};
        vecs[1]  = '{1'b0, 1,  5'd2,  7'd0, 10'b0100000000};
        vecs[2]  = '{1'b0, 11, 5'd13, 7'd0, 10'b0010000000};
        vecs[3]  = '{1'b0, 8,  5'd21, 7'd0, 10'b0001000000};
        vecs[4]  = '{1'b0, 7,  5'd28, 7'd0, 10'b0000100000};
        vecs[5]  = '{1'b0, 1,  5'd29, 7'd0, 10'b0000010100};
        vecs[6]  = '{1'b0, 1,  5'd1,  7'd1, 10'b1000001000};
        vecs[7]  = '{1'b0, 28, 5'd29, 7'd1, 10'b0000011100};
        vecs[8]  = '{1'b0, 29, 5'd29, 7'd2, 10'b0000010100};
        vecs[9]  = '{1'b0, 29, 5'd29, 7'd3, 10'b0000011101};
        vecs[10] = '{1'b0, 29, 5'd29, 7'd4, 10'b0000010100};
        vecs[11] = '{1'b0, 1,  5'd1,  7'd5, 10'b1000001000};
        vecs[12] = '{1'b0, 12, 5'd13, 7'd5, 10'b0010001000};
        vecs[13] = '{1'b1, 10, 5'd13, 7'd5, 10'b0010001000};
        vecs[14] = '{1'b0, 1,  5'd14, 7'd5, 10'b0000001000};

        // async reset is visible before any clock edge
        #2;
        check("reset_bit_async", 32'(tif.BIT_TIME), 32'd1);
        check("reset_sync_err", 32'(tif.SYNC_ERR), 32'd0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            tif.HOLD = vecs[i].hold;
            step(vecs[i].n_clk);
            check($sformatf("vec%0d_bit", i),  32'(tif.BIT_TIME),  32'(vecs[i].exp_bit));
            check($sformatf("vec%0d_word", i), 32'(tif.WORD_TIME), 32'(vecs[i].exp_word));
            check($sformatf("vec%0d_strb", i), 32'(strobes()),     32'(vecs[i].exp_strb));
        end
        tif.HOLD = 1'b0;

        // full revolution: position model, T1 count, single REV_END at clock 3131
        do_reset();
        t1_count = 0;
        rev_count = 0;
        rev_cycle = -1;
        track_err = 0;
        for (int k = 0; k < 3132; k++) begin
            exp_q.push_back({5'(k % 29 + 1), 7'(k / 29)});
        end
        for (int k = 0; k < 3132; k++) begin
            exp_pos = exp_q.pop_front();
            if ({tif.BIT_TIME, tif.WORD_TIME} !== exp_pos) begin
                if (track_err == 0)
                    $display("FAIL rev_track at clock %0d: got bit %0d word %0d expected bit %0d word %0d",
                             k, tif.BIT_TIME, tif.WORD_TIME, exp_pos[11:7], exp_pos[6:0]);
                track_err++;
            end
            if (tif.T1) t1_count++;
            if (tif.REV_END) begin
                rev_count++;
                rev_cycle = k;
            end
            step(1);
        end
        n_tests++;
        if (track_err != 0) n_fail++;
        check("rev_t1_count", 32'(t1_count), 32'd108);
        check("rev_end_count", 32'(rev_count), 32'd1);
        check("rev_end_cycle", 32'(rev_cycle), 32'd3131);
        check("rev_wrap_bit", 32'(tif.BIT_TIME), 32'd1);
        check("rev_wrap_word", 32'(tif.WORD_TIME), 32'd0);

        // async reset mid-cycle at word 57 bit 20
        do_reset();
        step(57 * 29 + 19);
        check("pre_rst_bit", 32'(tif.BIT_TIME), 32'd20);
        check("pre_rst_word", 32'(tif.WORD_TIME), 32'd57);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_bit", 32'(tif.BIT_TIME), 32'd1);
        check("async_rst_word", 32'(tif.WORD_TIME), 32'd0);
        check("async_rst_strb", 32'(strobes()), 32'(10'b1000000000));
        rst = 1'b0;
        step(1);
        check("post_rst_bit", 32'(tif.BIT_TIME), 32'd2);

`ifdef G15_TIMING_ORIGIN_EN
        // origin slip at word 50 bit 7
        do_reset();
        step(50 * 29 + 6);
        check("org_pre_bit", 32'(tif.BIT_TIME), 32'd7);
        check("org_pre_word", 32'(tif.WORD_TIME), 32'd50);
        tif.ORIGIN = 1'b1;
        step(1);
        tif.ORIGIN = 1'b0;
        check("org_slip_bit", 32'(tif.BIT_TIME), 32'd1);
        check("org_slip_word", 32'(tif.WORD_TIME), 32'd0);
        check("org_slip_err", 32'(tif.SYNC_ERR), 32'd1);
        step(40);
        check("org_err_sticky", 32'(tif.SYNC_ERR), 32'd1);

        // origin with HOLD is ignored
        do_reset();
        step(5);
        tif.HOLD = 1'b1;
        tif.ORIGIN = 1'b1;
        step(1);
        tif.HOLD = 1'b0;
        tif.ORIGIN = 1'b0;
        check("org_hold_bit", 32'(tif.BIT_TIME), 32'd6);
        check("org_hold_err", 32'(tif.SYNC_ERR), 32'd0);

        // origin exactly at REV_END is the normal case
        do_reset();
        step(3131);
        check("org_rev_end", 32'(tif.REV_END), 32'd1);
        tif.ORIGIN = 1'b1;
        step(1);
        tif.ORIGIN = 1'b0;
        check("org_ok_bit", 32'(tif.BIT_TIME), 32'd1);
        check("org_ok_word", 32'(tif.WORD_TIME), 32'd0);
        check("org_ok_err", 32'(tif.SYNC_ERR), 32'd0);
`else
        // origin has no effect when the feature is built out
        do_reset();
        step(50 * 29 + 6);
        tif.ORIGIN = 1'b1;
        step(1);
        tif.ORIGIN = 1'b0;
        check("org_off_bit", 32'(tif.BIT_TIME), 32'd8);
        check("org_off_word", 32'(tif.WORD_TIME), 32'd50);
        check("org_off_err", 32'(tif.SYNC_ERR), 32'd0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
